// File: rtl/bus8088_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bus8088_pkg
//  Description : Shared types for the 8088-style bus-cycle master. Provides
//                the one-hot bus state encoding, the latched request record
//                and the active-low strobe levels.
//  Revision    : 1.0  initial release
// ============================================================================
package bus8088_pkg;

  localparam int BUS_ADDR_WIDTH = 20;
  localparam int BUS_DATA_WIDTH = 8;

  // Strobe levels for the active-low RD/WR lines
  localparam logic ASSERTED_LOW    = 1'b0;
  localparam logic DEASSERTED_HIGH = 1'b1;

  // One-hot bus cycle states
  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_T1   = 6'b000010,
    ST_T2   = 6'b000100,
    ST_T3   = 6'b001000,
    ST_TW   = 6'b010000,
    ST_T4   = 6'b100000
  } bus_state_t;

  // Request fields captured on acceptance
  typedef struct packed {
    logic                      write;
    logic                      io;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_DATA_WIDTH-1:0] wdata;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/bus_cycle_master_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bus_cycle_master_if
//  Description : Request/response handshake plus the 8088-style bus control
//                and address lines. The bidirectional DATA bus is a separate
//                port of the master so the tristate stays at module level.
//  Modports    : master - the bus_cycle_master side
//                slave  - requester / memory-IO side
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_cycle_master_if
  import bus8088_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
);

  // request channel
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic                  REQ_IO;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  // response channel
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  // bus control
  logic                  ALE;
  logic                  RD;
  logic                  WR;
  logic                  IOM;
  logic                  DEN;
  logic                  DTR;
  logic                  READY;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output ALE, RD, WR, IOM, DEN, DTR, ADDRESS
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  ALE, RD, WR, IOM, DEN, DTR, ADDRESS
  );

endinterface
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait_timer
//  Description : Wait-state counter for the bus-cycle master. Cleared while
//                the bus is in T2, counts once per TW cycle, and flags when
//                the count reaches TIMEOUT_CYCLES-1. Only built when
//                BUS_TIMEOUT_EN is defined.
//  Ports       : CLK, RESET   clock / synchronous active-high reset
//                clear_i      restart the count
//                inc_i        count one wait state
//                expired_o    count == TIMEOUT_CYCLES-1
//  Revision    : 1.0  initial release
// ============================================================================
module bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;

  assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal value so a stalled bus never wraps the count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_master
//  Description : 8088-style bus-cycle generator. Accepts a valid/ready
//                request and runs it as T1,T2,T3,[TW..],T4 bus states,
//                driving ALE, RD, WR, IOM, DEN, DTR, ADDRESS and DATA.
//                A one-cycle RSP_VALID strobe in T4 completes every transfer
//                and carries read data.
//  Ports       : CLK, RESET   clock / synchronous active-high reset
//                bus          bus_cycle_master_if.master (request, response,
//                             bus control, ADDRESS, READY)
//                DATA         bidirectional data bus
//  Options     : BUS_TIMEOUT_EN - abort a cycle after TIMEOUT_CYCLES wait
//                states with RSP_ERR=1 and RSP_RDATA all ones.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_cycle_master
  import bus8088_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_cycle_master_if.master    bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  bus_state_t            state_q, state_d;
  bus_req_t              req_q, req_d;
  logic                  ale_q, ale_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  den_q, den_d;
  logic                  dtr_q, dtr_d;
  logic                  data_oe_q, data_oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic req_ready;
  logic accept;
  logic sample_ready;
  logic timeout_hit;
  logic strobe_d;

  assign req_ready    = (state_q == ST_IDLE) || (state_q == ST_T4);
  assign accept       = bus.REQ_VALID && req_ready;
  assign sample_ready = ((state_q == ST_T3) || (state_q == ST_TW)) && bus.READY;

`ifdef BUS_TIMEOUT_EN
  logic timer_expired;
  logic rsp_err_q;

  bus_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear_i   (state_q == ST_T2),
    .inc_i     (state_q == ST_TW),
    .expired_o (timer_expired)
  );

  // A ready slave always wins over an expiring timer
  assign timeout_hit = (state_q == ST_TW) && !bus.READY && timer_expired;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= (state_d == ST_T4) && timeout_hit;
    end
  end

  assign bus.RSP_ERR = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign bus.RSP_ERR        = 1'b0;
`endif

  // Next state, request capture and the output levels for the next state.
  // Outputs are registered from these so every bus line is glitch free.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE, ST_T4: begin
        if (accept) begin
          state_d       = ST_T1;
          req_d.write   = bus.REQ_WRITE;
          req_d.io      = bus.REQ_IO;
          req_d.addr    = BUS_ADDR_WIDTH'(bus.REQ_ADDR);
          req_d.wdata   = BUS_DATA_WIDTH'(bus.REQ_WDATA);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3, ST_TW: begin
        if (bus.READY || timeout_hit) begin
          state_d = ST_T4;
        end else begin
          state_d = ST_TW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    strobe_d    = (state_d == ST_T2) || (state_d == ST_T3) || (state_d == ST_TW);
    ale_d       = (state_d == ST_T1);
    rd_n_d      = (strobe_d && !req_d.write) ? ASSERTED_LOW : DEASSERTED_HIGH;
    wr_n_d      = (strobe_d &&  req_d.write) ? ASSERTED_LOW : DEASSERTED_HIGH;
    // DEN stays up through T4 on writes so data is held past the WR edge
    den_d       = strobe_d || ((state_d == ST_T4) && req_d.write);
    dtr_d       = (state_d != ST_IDLE) && req_d.write;
    data_oe_d   = req_d.write && (strobe_d || (state_d == ST_T4));
    rsp_valid_d = (state_d == ST_T4);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ale_q       <= 1'b0;
      rd_n_q      <= DEASSERTED_HIGH;
      wr_n_q      <= DEASSERTED_HIGH;
      den_q       <= 1'b0;
      dtr_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      den_q       <= den_d;
      dtr_q       <= dtr_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      if (timeout_hit) begin
        rsp_rdata_q <= '1;
      end else if (sample_ready && !req_q.write) begin
        rsp_rdata_q <= DATA;
      end
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.ALE       = ale_q;
  assign bus.RD        = rd_n_q;
  assign bus.WR        = wr_n_q;
  assign bus.DEN       = den_q;
  assign bus.DTR       = dtr_q;
  assign bus.IOM       = req_q.io;
  // Address and space stay valid from T1 until the next accepted request
  assign bus.ADDRESS   = ADDR_WIDTH'(req_q.addr);
  assign DATA          = data_oe_q ? DATA_WIDTH'(req_q.wdata) : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_cycle_master
//  Description : Self-checking bench for bus_cycle_master with a slave
//                memory model and a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_cycle_master;

  localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  wire  [7:0] data_bus;
  logic       slave_oe;
  logic [7:0] slave_dout;

  always #5 clk = ~clk;

  bus_cycle_master_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) ifc ();

  bus_cycle_master #(
    .ADDR_WIDTH     (20),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifc),
    .DATA  (data_bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave: memory/IO space indexed by {IOM, addr[7:0]} -----
  logic [7:0] slave_mem [512];
  logic [7:0] model_mem [512];
  logic       wr_prev = 1'b0;

  assign slave_oe   = (ifc.RD == 1'b0);
  assign slave_dout = slave_mem[{ifc.IOM, ifc.ADDRESS[7:0]}];
  assign data_bus   = slave_oe ? slave_dout : 8'bz;

  // the slave commits a write at the end of T3/TW (WR already low a cycle)
  always @(posedge clk) begin
    if (!rst && ifc.WR == 1'b0 && wr_prev && ifc.READY)
      slave_mem[{ifc.IOM, ifc.ADDRESS[7:0]}] = data_bus;
    wr_prev = !rst && (ifc.WR == 1'b0);
  end

  // ---------------- reference model: cycles since T1 of the current transfer
  int         m_c   = -1;     // -1 idle, 0 = T1, 1 = T2, >=2 strobe phase
  bit         m_fin = 1'b0;   // completion cycle (response)
  bit         m_w, m_io, m_err;
  logic [19:0] m_addr;
  logic [7:0]  m_wd, m_rd;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_c = -1; m_fin = 0; m_addr = '0; m_io = 0; m_w = 0; m_rd = '0; m_err = 0;
    end else if (m_c < 0 || m_fin) begin
      m_fin = 0;
      if (ifc.REQ_VALID) begin
        m_c = 0; m_w = ifc.REQ_WRITE; m_io = ifc.REQ_IO;
        m_addr = ifc.REQ_ADDR; m_wd = ifc.REQ_WDATA;
      end else begin
        m_c = -1;
      end
    end else if (m_c < 2) begin
      m_c++;
    end else if (ifc.READY) begin
      m_fin = 1; m_err = 0;
      if (m_w) model_mem[{m_io, m_addr[7:0]}] = m_wd;
      else     m_rd = model_mem[{m_io, m_addr[7:0]}];
    end else if (TO_EN && (m_c - 2) == TO) begin
      m_fin = 1; m_err = 1; m_rd = 8'hFF;
    end else begin
      m_c++;
    end
    chk_en = 1'b1;
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit idle;
      logic e_rr, e_ale, e_rd, e_wr, e_den, e_rv;
      idle = (m_c < 0);
      if (idle)       begin e_rr = 1; e_ale = 0; e_rd = 1;    e_wr = 1;     e_den = 0;   e_rv = 0; end
      else if (m_fin) begin e_rr = 1; e_ale = 0; e_rd = 1;    e_wr = 1;     e_den = m_w; e_rv = 1; end
      else if (m_c == 0) begin e_rr = 0; e_ale = 1; e_rd = 1; e_wr = 1;     e_den = 0;   e_rv = 0; end
      else            begin e_rr = 0; e_ale = 0; e_rd = m_w;  e_wr = !m_w;  e_den = 1;   e_rv = 0; end
      chk("REQ_READY", 32'(ifc.REQ_READY), 32'(e_rr));
      chk("ALE",       32'(ifc.ALE),       32'(e_ale));
      chk("RD",        32'(ifc.RD),        32'(e_rd));
      chk("WR",        32'(ifc.WR),        32'(e_wr));
      chk("DEN",       32'(ifc.DEN),       32'(e_den));
      chk("RSP_VALID", 32'(ifc.RSP_VALID), 32'(e_rv));
      chk("ADDRESS",   32'(ifc.ADDRESS),   32'(m_addr));
      chk("IOM",       32'(ifc.IOM),       32'(m_io));
      if (!idle) chk("DTR", 32'(ifc.DTR), 32'(m_w));
      if (m_fin) begin
        chk("RSP_ERR", 32'(ifc.RSP_ERR), 32'(m_err));
        if (!m_w || m_err) chk("RSP_RDATA", 32'(ifc.RSP_RDATA), 32'(m_rd));
      end
      if (!idle && m_w && (m_fin || m_c >= 1)) chk("DATA", 32'(data_bus), 32'(m_wd));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic issue(input bit w, input bit io, input logic [19:0] a, input logic [7:0] d);
    bit rdy;
    ifc.REQ_VALID = 1'b1; ifc.REQ_WRITE = w; ifc.REQ_IO = io;
    ifc.REQ_ADDR = a; ifc.REQ_WDATA = d;
    for (int n = 0; n < 200; n++) begin
      rdy = ifc.REQ_READY;
      @(negedge clk);
      if (rdy) begin
        // junk on unaccepted fields must be ignored
        ifc.REQ_VALID = 1'b0;
        ifc.REQ_WRITE = 1'($urandom); ifc.REQ_IO = 1'($urandom);
        ifc.REQ_ADDR = 20'($urandom); ifc.REQ_WDATA = 8'($urandom);
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    ifc.REQ_VALID = 1'b0;
  endtask

  // Starts at the T1 negedge; READY low for nwait samples after T2.
  task automatic wait_rsp(input int nwait, input int bound, output int len, output bit got);
    got = 0; len = 0;
    for (int k = 0; k <= bound; k++) begin
      if (ifc.RSP_VALID) begin got = 1; len = k + 1; return; end
      if (k >= 2 + nwait) ifc.READY = 1'b1;
      else if (k < 2)     ifc.READY = 1'($urandom);
      else                ifc.READY = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int  len, pulses, last, ales, idx, acc, guard;
    bit  got, rdy;
    logic [7:0] v;

    for (int i = 0; i < 512; i++) begin
      v = 8'($urandom); slave_mem[i] = v; model_mem[i] = v;
    end
    slave_mem[{1'b0, 8'h10}] = 8'h5A; model_mem[{1'b0, 8'h10}] = 8'h5A;

    rst = 1'b1; ifc.REQ_VALID = 0; ifc.REQ_WRITE = 0; ifc.REQ_IO = 0;
    ifc.REQ_ADDR = '0; ifc.REQ_WDATA = '0; ifc.READY = 0;
    repeat (3) @(negedge clk);
    chk("reset_REQ_READY", 32'(ifc.REQ_READY), 32'd1);
    chk("reset_RD",        32'(ifc.RD),        32'd1);
    chk("reset_WR",        32'(ifc.WR),        32'd1);
    chk("reset_ALE",       32'(ifc.ALE),       32'd0);
    chk("reset_RSP_RDATA", 32'(ifc.RSP_RDATA), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // memory read of preloaded 0x5A, zero waits
    issue(1'b0, 1'b0, 20'h00010, 8'h00);
    chk("rd_T1_ALE", 32'(ifc.ALE), 32'd1);
    chk("rd_T1_IOM", 32'(ifc.IOM), 32'd0);
    wait_rsp(0, 20, len, got);
    chk("rd_got", 32'(got), 32'd1);
    chk("rd_len", 32'(len), 32'd4);
    chk("rd_data", 32'(ifc.RSP_RDATA), 32'h5A);

    // IO write then readback
    @(negedge clk);
    issue(1'b1, 1'b1, 20'h003F8, 8'hC3);
    chk("wr_T1_IOM", 32'(ifc.IOM), 32'd1);
    chk("wr_T1_DTR", 32'(ifc.DTR), 32'd1);
    wait_rsp(0, 20, len, got);
    chk("wr_len", 32'(len), 32'd4);
    issue(1'b0, 1'b1, 20'h003F8, 8'h00);
    wait_rsp(0, 20, len, got);
    chk("wr_readback", 32'(ifc.RSP_RDATA), 32'hC3);

    // back-to-back: three reads with REQ_VALID held
    @(negedge clk);
    ifc.READY = 1'b1;
    ifc.REQ_VALID = 1'b1; ifc.REQ_WRITE = 0; ifc.REQ_IO = 0; ifc.REQ_ADDR = 20'($urandom);
    idx = -1; acc = 0; pulses = 0; last = -1; ales = 0; guard = 0;
    while (idx < 11 && guard < 40) begin
      rdy = ifc.REQ_READY && ifc.REQ_VALID;
      @(negedge clk); guard++;
      if (idx >= 0) idx++;
      if (rdy) begin
        acc++;
        if (idx < 0) idx = 0;
        if (acc < 3) ifc.REQ_ADDR = 20'($urandom);
        else         ifc.REQ_VALID = 1'b0;
      end
      if (idx >= 0) begin
        if (ifc.RSP_VALID) begin pulses++; last = idx; end
        if (ifc.ALE) ales++;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_last",   32'(last),   32'd11);
    chk("b2b_T1s",    32'(ales),   32'd3);

    // three wait states
    @(negedge clk);
    issue(1'b0, 1'b0, 20'($urandom), 8'h00);
    wait_rsp(3, 30, len, got);
    chk("wait_len", 32'(len), 32'd7);

    // reset in T3 of a write
    issue(1'b1, 1'b0, 20'($urandom), 8'($urandom));
    ifc.READY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_WR",        32'(ifc.WR),        32'd1);
    chk("rst_DEN",       32'(ifc.DEN),       32'd0);
    chk("rst_RSP_VALID", 32'(ifc.RSP_VALID), 32'd0);
    chk("rst_REQ_READY", 32'(ifc.REQ_READY), 32'd1);
    chk("rst_RSP_RDATA", 32'(ifc.RSP_RDATA), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(ifc.RSP_VALID), 32'd0);
    end

    // READY stuck low
    issue(1'b0, 1'b0, 20'($urandom), 8'h00);
`ifdef BUS_TIMEOUT_EN
    wait_rsp(1000, 40, len, got);
    chk("to_got",   32'(got),           32'd1);
    chk("to_len",   32'(len),           32'd8);
    chk("to_err",   32'(ifc.RSP_ERR),   32'd1);
    chk("to_rdata", 32'(ifc.RSP_RDATA), 32'hFF);
`else
    wait_rsp(1000, 100, len, got);
    chk("stall_no_rsp", 32'(got), 32'd0);
    wait_rsp(0, 10, len, got);
    chk("stall_release", 32'(got), 32'd1);
`endif

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom));
      wait_rsp($urandom_range(0, 5), 60, len, got);
      chk("rand_got", 32'(got), 32'd1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
